traffic_light_monitor: RTL

- Passive checker on the R/G/Y lamp outputs of the intersection controller. It is the receiving end of the lamp interface.
- Decodes the lamp code, locks onto the 7-step phase sequence and measures each phase's length in clocks.
- Flags illegal lamp combinations, out-of-order phases and timing violations.
- Sits beside the controller in the top level and feeds the fault/status register.

---
 rtl/traffic_light_monitor_if.sv | 11 +
 rtl/traffic_light_monitor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor_if.sv
// Lamp bus between the intersection controller (master) and its monitors (slave).
// Plain wires: no handshake and no backpressure, the receiver samples every clock.
interface traffic_light_monitor_if;
    logic R;
    logic G;
    logic Y;
    logic pass;

    modport master (output R, G, Y, pass);
    modport slave  (input  R, G, Y, pass);
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive lamp-sequence checker: locks onto the G1,B1,G2,B2,G3,Y,R cycle and flags illegal, out-of-order or mistimed lamps.
// Status and errors appear 1 clk after the edge that samples a change; no backpressure, the controller is never stalled.
module traffic_light_monitor #(
    parameter int T_G1 = 1024,
    parameter int T_FL = 128,
    parameter int T_Y  = 512,
    parameter int T_R  = 1024,
    parameter int TOL  = 2,
    parameter int CW   = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    traffic_light_monitor_if.slave lamp,
    output logic [2:0]             step,
    output logic                   locked,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [7:0]             err_cnt,
    output logic [CW-1:0]          run_len
);

    localparam logic [2:0] C_BLANK = 3'b000;
    localparam logic [2:0] C_GREEN = 3'b010;
    localparam logic [2:0] C_YEL   = 3'b001;
    localparam logic [2:0] C_RED   = 3'b100;

    localparam logic [2:0] S_UNSYNC = 3'd0;
    localparam logic [2:0] S_G1     = 3'd1;
    localparam logic [2:0] S_B1     = 3'd2;
    localparam logic [2:0] S_R      = 3'd7;

    localparam logic [1:0] E_ILLEGAL = 2'd1;
    localparam logic [1:0] E_SEQ     = 2'd2;
    localparam logic [1:0] E_TIME    = 2'd3;

    localparam logic [CW:0]   TOL_W   = (CW+1)'(TOL);
    localparam logic [CW-1:0] RUN_MAX = '1;

    function automatic logic [2:0] lamp_of(input logic [2:0] s);
        case (s)
            3'd1, 3'd3, 3'd5: lamp_of = C_GREEN;
            3'd6:             lamp_of = C_YEL;
            3'd7:             lamp_of = C_RED;
            default:          lamp_of = C_BLANK;
        endcase
    endfunction

    function automatic logic [CW-1:0] exp_of(input logic [2:0] s);
        case (s)
            3'd1:    exp_of = CW'(T_G1);
            3'd6:    exp_of = CW'(T_Y);
            3'd7:    exp_of = CW'(T_R);
            default: exp_of = CW'(T_FL);
        endcase
    endfunction

    logic [2:0]    code;
    logic [2:0]    prev_code;
    logic          pass_pend;
    logic          change;
    logic          code_legal;
    logic          prev_legal;
    logic [2:0]    step_inc;
    logic [CW:0]   len_w;
    logic [CW:0]   exp_w;
    logic [CW:0]   hi_w;
    logic [CW-1:0] run_d;
    logic [2:0]    step_d;
    logic          locked_d;
    logic          pend_d;
    logic          err_d;
    logic [1:0]    cause_d;

    assign code = {lamp.R, lamp.G, lamp.Y};

    always_comb begin
        change     = (code != prev_code);
        code_legal = (code == C_BLANK) || (code == C_GREEN) || (code == C_YEL) || (code == C_RED);
        prev_legal = (prev_code == C_BLANK) || (prev_code == C_GREEN) ||
                     (prev_code == C_YEL) || (prev_code == C_RED);
        step_inc   = (step == S_R) ? S_G1 : step + 3'd1;
        len_w      = {1'b0, run_len};
        exp_w      = {1'b0, exp_of(step)};
        hi_w       = exp_w + TOL_W;

        if (change)
            run_d = {{(CW-1){1'b0}}, 1'b1};
        else if (run_len == RUN_MAX)
            run_d = run_len;
        else
            run_d = run_len + 1'b1;

        step_d   = step;
        locked_d = locked;
        pend_d   = pass_pend;
        err_d    = 1'b0;
        cause_d  = 2'd0;

        // Only the first sample of an illegal run counts; a held illegal code stays quiet.
        if (!code_legal && prev_legal) begin
            err_d   = 1'b1;
            cause_d = E_ILLEGAL;
        end else if (locked) begin
            if (change) begin
                pend_d = 1'b0;
                if (pass_pend && code == C_GREEN) begin
                    step_d = S_G1;
                end else if (code != lamp_of(step_inc)) begin
                    err_d   = 1'b1;
                    cause_d = E_SEQ;
                end else if (len_w + TOL_W < exp_w || len_w > hi_w) begin
                    err_d   = 1'b1;
                    cause_d = E_TIME;
                end else begin
                    step_d = step_inc;
                end
            end else if (len_w == hi_w) begin
                // run_len is about to pass the upper tolerance bound: stuck lamp.
                err_d   = 1'b1;
                cause_d = E_TIME;
            end
        end else if (change && prev_code == C_GREEN && code == C_BLANK) begin
            step_d   = S_B1;
            locked_d = 1'b1;
        end

        // A request seen on a change edge only arms the following change.
        if (lamp.pass && locked && step != S_G1)
            pend_d = 1'b1;

        if (err_d) begin
            step_d   = S_UNSYNC;
            locked_d = 1'b0;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_code <= C_BLANK;
            run_len   <= '0;
            step      <= S_UNSYNC;
            locked    <= 1'b0;
            pass_pend <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            err_cnt   <= 8'd0;
        end else begin
            prev_code <= code;
            run_len   <= run_d;
            step      <= step_d;
            locked    <= locked_d;
            pass_pend <= pend_d;
            err       <= err_d;
            if (err_d) begin
                err_code <= cause_d;
                if (err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
